// File: rtl/denormalizacao.sv
// -----------------------------------------------------------------------------
// denormalizacao
//
// Undoes the log2 normalization stage. A normalized mantissa has its leading
// one at bit NORM_BIT, and exp_in is the exponent that normalization
// produced. The original fixed-point value is restored by a logical right
// shift of (NORM_BIT - exp_in) bits, done one bit per clock. Bits shifted
// out are OR-ed into the inexact flag. Malformed operands raise err.
//
// Handshake: start is sampled only while ready=1. An accepted start clears
// value_out, inexact and err. done is a one-cycle pulse. value_out,
// inexact and err stay valid until the next accepted start. ready is high
// in the done cycle, so a back-to-back start is accepted there.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   start      : operation request, sampled when ready=1
//   mant_in    : normalized mantissa [WIDTH-1:0]
//   exp_in     : exponent [EXP_W-1:0], legal range 0..NORM_BIT
//   ready      : high in IDLE, a new start can be accepted
//   done       : one-cycle pulse, result outputs valid
//   value_out  : denormalized result [WIDTH-1:0]
//   inexact    : OR of all bits shifted out
//   err        : operand error
//   state_dbg  : current FSM state (0=IDLE, 1=SHIFT) for observation
// -----------------------------------------------------------------------------
module denormalizacao #(
    parameter int WIDTH    = 42,
    parameter int NORM_BIT = 8,
    parameter int EXP_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mant_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] value_out,
    output logic             inexact,
    output logic             err,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [EXP_W-1:0] NB = NORM_BIT[EXP_W-1:0];

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [EXP_W-1:0] cnt;
    logic             sticky;
    logic             err_r;

    // Operand checks on the incoming mantissa.
    logic             lead_missing;
    logic             high_bits_set;

    assign lead_missing  = ~mant_in[NORM_BIT];
    assign high_bits_set = |(mant_in >> (NORM_BIT + 1));
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            value_out <= '0;
            inexact   <= 1'b0;
            err       <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        value_out <= '0;
                        inexact   <= 1'b0;
                        err       <= 1'b0;
                        sticky    <= 1'b0;
                        ready     <= 1'b0;
                        state     <= SHIFT;
                        // Range check first so NB - exp_in never wraps.
                        if (exp_in > NB) begin
                            err_r <= 1'b1;
                            cnt   <= '0;
                            shreg <= '0;
                        end else begin
                            err_r <= lead_missing | high_bits_set;
                            cnt   <= NB - exp_in;
                            shreg <= mant_in;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg  <= shreg >> 1;
                        sticky <= sticky | shreg[0];
                        cnt    <= cnt - 1'b1;
                    end else begin
                        value_out <= shreg;
                        inexact   <= sticky;
                        err       <= err_r;
                        done      <= 1'b1;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_denormalizacao.sv
// -----------------------------------------------------------------------------
// tb_denormalizacao
//
// Directed, table-driven bench for denormalizacao. Each table record holds
// the operands plus the hand-computed result, flags and latency (edges from
// the accepting edge to the edge that raises done). Reset-mid-shift and
// continuous-start handshake sequences are written out by hand.
// -----------------------------------------------------------------------------
module tb_denormalizacao;

    localparam int WIDTH    = 42;
    localparam int NORM_BIT = 8;
    localparam int EXP_W    = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] mant_in;
    logic [EXP_W-1:0] exp_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] value_out;
    logic             inexact;
    logic             err;
    logic             state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] mant;
        logic [EXP_W-1:0] expo;
        logic [WIDTH-1:0] value;
        logic             inex;
        logic             er;
        int               lat;
    } vec_t;

    vec_t vecs[$];

    denormalizacao #(
        .WIDTH(WIDTH),
        .NORM_BIT(NORM_BIT),
        .EXP_W(EXP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mant_in(mant_in),
        .exp_in(exp_in),
        .ready(ready),
        .done(done),
        .value_out(value_out),
        .inexact(inexact),
        .err(err),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        else
            n_pass++;
    endtask

    task automatic add_vec(input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e,
                           input logic [WIDTH-1:0] v, input logic ix, input logic er,
                           input int lat);
        vec_t t;
        t.mant  = m;
        t.expo  = e;
        t.value = v;
        t.inex  = ix;
        t.er    = er;
        t.lat   = lat;
        vecs.push_back(t);
    endtask

    // Driver: one operation, wait for done (bounded), compare against scoreboard.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        logic [WIDTH-1:0] expv;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready_before"}, 64'(ready), 64'd1);
        exp_q.push_back(v.value);
        start   = 1'b1;
        mant_in = v.mant;
        exp_in  = v.expo;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy"}, {62'd0, ready, state_dbg}, {62'd0, 1'b0, 1'b1});
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        expv = exp_q.pop_front();
        chk({tag, " latency"}, 64'(n), 64'(v.lat));
        chk({tag, " value"}, 64'(value_out), 64'(expv));
        chk({tag, " flags"}, {61'd0, inexact, err, ready}, {61'd0, v.inex, v.er, 1'b1});
        @(negedge clk);
        chk({tag, " done_pulse_held"}, {21'd0, done, value_out}, {21'd0, 1'b0, expv});
    endtask

    initial begin
        int n;
        int bad;
        start   = 1'b0;
        mant_in = '0;
        exp_in  = '0;
        rst     = 1'b1;

        // Stimulus table: mant, exp, value, inexact, err, latency
        add_vec(42'h1A0, 4'd5,  42'h34,  1'b0, 1'b0, 4);
        add_vec(42'h1A5, 4'd8,  42'h1A5, 1'b0, 1'b0, 1);
        add_vec(42'h1A5, 4'd6,  42'h69,  1'b1, 1'b0, 3);
        add_vec(42'h1A5, 4'd9,  42'h0,   1'b0, 1'b1, 1);
        add_vec(42'h1A5, 4'd15, 42'h0,   1'b0, 1'b1, 1);
        add_vec(42'h0A0, 4'd8,  42'h0A0, 1'b0, 1'b1, 1);
        add_vec(42'h000, 4'd3,  42'h0,   1'b0, 1'b1, 6);
        add_vec(42'h301, 4'd7,  42'h180, 1'b1, 1'b1, 2);
        add_vec(42'h200_0000_0100, 4'd8, 42'h200_0000_0100, 1'b0, 1'b1, 1);
        for (int e = 0; e <= NORM_BIT; e++)
            add_vec(42'h1FF >> (NORM_BIT - e), 4'(e), 42'h1FF >> (NORM_BIT - e),
                    (e < NORM_BIT), 1'b0, NORM_BIT + 1 - e);
        // Sweep records above carry the operand in .mant; fix it to 0x1FF.
        for (int i = 0; i < vecs.size(); i++)
            if (i >= 9) vecs[i].mant = 42'h1FF;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {39'd0, ready, done, inexact, err, state_dbg},
            {39'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_value", 64'(value_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-shift: accept at edge 0, reset lands on edge 3.
        chk("pre_reset_value_nonzero", 64'(value_out != 0), 64'd1);
        start   = 1'b1;
        mant_in = 42'h1A0;
        exp_in  = 4'd0;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) bad++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_state", {59'd0, ready, done, inexact, err, state_dbg},
            {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("midreset_value", 64'(value_out), 64'd0);
        repeat (12) begin
            @(negedge clk);
            if (done) bad++;
        end
        chk("midreset_no_done", 64'(bad), 64'd0);

        // Continuous start: accepts on edges 0,3,6,9; done after edges 2,5,8,11.
        start   = 1'b1;
        mant_in = 42'h100;
        exp_in  = 4'd7;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("hs_done_%0d", k), {62'd0, done, ready},
                {62'd0, (k % 3 == 2), (k % 3 == 2)});
            if (k % 3 == 2)
                chk($sformatf("hs_value_%0d", k), 64'(value_out), 64'h80);
        end
        start = 1'b0;
        @(negedge clk);
        chk("hs_idle", {62'd0, done, ready}, {62'd0, 1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
